// File: rtl/can_error_frame_rx_if.sv
// Bus-side signal bundle for the CAN error-frame receiver: sampled bit and enable in,
// detection pulses and dominant-run count out.
interface can_error_frame_rx_if #(
  parameter int unsigned CNT_W = 4
);
  logic             rx_en;
  logic             rx_bit;
  logic             err_flag_det;
  logic             err_frame_done;
  logic             delim_err;
  logic             excess_dom;
  logic             in_error;
  logic [CNT_W-1:0] dom_cnt;

  modport master (
    output rx_en,
    output rx_bit,
    input  err_flag_det,
    input  err_frame_done,
    input  delim_err,
    input  excess_dom,
    input  in_error,
    input  dom_cnt
  );

  modport slave (
    input  rx_en,
    input  rx_bit,
    output err_flag_det,
    output err_frame_done,
    output delim_err,
    output excess_dom,
    output in_error,
    output dom_cnt
  );
endinterface

// File: rtl/can_error_frame_rx.sv
// CAN error-frame receiver: detects error flags (including superposed flags), tracks the
// recessive error delimiter and reports completion, delimiter form errors and excess dominance.
module can_error_frame_rx #(
  parameter int unsigned FLAG_LEN  = 6,
  parameter int unsigned MAX_DOM   = 12,
  parameter int unsigned DELIM_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input logic                  SP,
  input logic                  reset,
  can_error_frame_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] FlagLenC  = CNT_W'(FLAG_LEN);
  localparam logic [CNT_W-1:0] ExcessC   = CNT_W'(MAX_DOM + 1);
  localparam logic [CNT_W-1:0] DelimLenC = CNT_W'(DELIM_LEN);
  localparam logic [CNT_W-1:0] OneC      = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StFlag, StDelim} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dom_q, dom_d;
  logic [CNT_W-1:0] del_q, del_d;
  logic [CNT_W-1:0] dom_inc, del_inc;
  logic             flag_q, flag_d;
  logic             done_q, done_d;
  logic             derr_q, derr_d;
  logic             exc_q, exc_d;
  logic             in_err_q, in_err_d;

  always_comb begin
    dom_inc = (dom_q == '1) ? dom_q : dom_q + OneC;
    del_inc = (del_q == '1) ? del_q : del_q + OneC;
  end

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    del_d   = del_q;
    flag_d  = 1'b0;
    done_d  = 1'b0;
    derr_d  = 1'b0;
    exc_d   = 1'b0;
    if (!bus.rx_en) begin
      state_d = StIdle;
      dom_d   = '0;
      del_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!bus.rx_bit) begin
            dom_d = dom_inc;
            if (dom_inc == FlagLenC) begin
              state_d = StFlag;
              flag_d  = 1'b1;
            end
          end else begin
            dom_d = '0;
          end
        end
        StFlag: begin
          if (!bus.rx_bit) begin
            dom_d = dom_inc;
            // Guard against repeat pulses if the threshold coincides with saturation.
            exc_d = (dom_inc == ExcessC) && (dom_q != ExcessC);
          end else begin
            state_d = StDelim;
            del_d   = OneC;
            dom_d   = '0;
          end
        end
        StDelim: begin
          if (bus.rx_bit) begin
            del_d = del_inc;
            if (del_inc == DelimLenC) begin
              state_d = StIdle;
              done_d  = 1'b1;
              del_d   = '0;
            end
          end else begin
            // The offending dominant bit seeds a possible new flag.
            state_d = StIdle;
            derr_d  = 1'b1;
            dom_d   = OneC;
            del_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          dom_d   = '0;
          del_d   = '0;
        end
      endcase
    end
    in_err_d = (state_d != StIdle);
  end

  always_ff @(posedge SP) begin
    if (!reset) begin
      state_q  <= StIdle;
      dom_q    <= '0;
      del_q    <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      derr_q   <= 1'b0;
      exc_q    <= 1'b0;
      in_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dom_q    <= dom_d;
      del_q    <= del_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
      derr_q   <= derr_d;
      exc_q    <= exc_d;
      in_err_q <= in_err_d;
    end
  end

  assign bus.err_flag_det   = flag_q;
  assign bus.err_frame_done = done_q;
  assign bus.delim_err      = derr_q;
  assign bus.excess_dom     = exc_q;
  assign bus.in_error       = in_err_q;
  assign bus.dom_cnt        = dom_q;

endmodule

// File: tb/tb_can_error_frame_rx.sv
// Bench for can_error_frame_rx: directed scenarios plus random bit streams, checked against
// an unbounded-integer behavioural model of the error-frame rules.
module tb_can_error_frame_rx;

  localparam int FLAG_LEN  = 6;
  localparam int MAX_DOM   = 12;
  localparam int DELIM_LEN = 8;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic SP;
  logic reset;

  can_error_frame_rx_if #(.CNT_W(CNT_W)) bus ();

  can_error_frame_rx #(
    .FLAG_LEN (FLAG_LEN),
    .MAX_DOM  (MAX_DOM),
    .DELIM_LEN(DELIM_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .SP   (SP),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial SP = 1'b0;
  always #5 SP = ~SP;

  int n_vec;
  int n_bad;

  // Reference model: run length is an unbounded integer, phase is "where in the frame we are".
  int  run_len;
  int  delim_bits;
  bit  in_frame;
  bit  after_flag;
  bit  e_flag, e_done, e_derr, e_exc;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    run_len    = 0;
    delim_bits = 0;
    in_frame   = 1'b0;
    after_flag = 1'b0;
    e_flag     = 1'b0;
    e_done     = 1'b0;
    e_derr     = 1'b0;
    e_exc      = 1'b0;
  endtask

  task automatic model_bit(input bit b);
    e_flag = 1'b0;
    e_done = 1'b0;
    e_derr = 1'b0;
    e_exc  = 1'b0;
    if (!in_frame) begin
      run_len = b ? 0 : run_len + 1;
      if (run_len == FLAG_LEN) begin
        e_flag     = 1'b1;
        in_frame   = 1'b1;
        after_flag = 1'b0;
      end
    end else if (!after_flag) begin
      if (!b) begin
        run_len++;
        e_exc = (run_len == MAX_DOM + 1);
      end else begin
        after_flag = 1'b1;
        delim_bits = 1;
        run_len    = 0;
      end
    end else if (b) begin
      delim_bits++;
      if (delim_bits == DELIM_LEN) begin
        e_done     = 1'b1;
        in_frame   = 1'b0;
        delim_bits = 0;
      end
    end else begin
      e_derr     = 1'b1;
      in_frame   = 1'b0;
      delim_bits = 0;
      run_len    = 1;
    end
  endtask

  task automatic step(input bit rst_n, input bit en, input bit b);
    @(negedge SP);
    reset      = rst_n;
    bus.rx_en  = en;
    bus.rx_bit = b;
    @(posedge SP);
    if (!rst_n || !en) model_clear();
    else model_bit(b);
    #1;
    check("err_flag_det",   int'(bus.err_flag_det),   int'(e_flag));
    check("err_frame_done", int'(bus.err_frame_done), int'(e_done));
    check("delim_err",      int'(bus.delim_err),      int'(e_derr));
    check("excess_dom",     int'(bus.excess_dom),     int'(e_exc));
    check("in_error",       int'(bus.in_error),       int'(in_frame));
    check("dom_cnt",        int'(bus.dom_cnt),        (run_len > CNT_MAX) ? CNT_MAX : run_len);
  endtask

  task automatic bits(input int n, input bit b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, b);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_clear();
    reset      = 1'b0;
    bus.rx_en  = 1'b0;
    bus.rx_bit = 1'b0;

    // Reset and enable clear
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    bits(3, 1'b1);
    // Short dominant run
    bits(5, 1'b0);
    bits(1, 1'b1);
    // Clean error frame
    bits(6, 1'b0);
    bits(8, 1'b1);
    // Superposed flag, excess, saturation
    bits(15, 1'b0);
    check("dom_cnt_saturated", int'(bus.dom_cnt), CNT_MAX);
    bits(8, 1'b1);
    // Delimiter violation and re-detection
    bits(6, 1'b0);
    bits(3, 1'b1);
    bits(1, 1'b0);
    check("delim_err_dom_cnt", int'(bus.dom_cnt), 1);
    bits(5, 1'b0);
    check("flag_redetect", int'(bus.err_flag_det), 1);
    bits(8, 1'b1);
    // Reset, then disable, mid-delimiter
    bits(6, 1'b0);
    bits(4, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    bits(4, 1'b1);
    bits(6, 1'b0);
    bits(4, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    bits(4, 1'b1);

    // Random runs biased towards flag-length dominant stretches
    for (int seg = 0; seg < 400; seg++) begin
      int  len;
      bit  lvl;
      lvl = seg[0];
      len = lvl ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) begin
        int r;
        r = int'($urandom_range(0, 59));
        if (r == 0) step(1'b0, 1'b1, lvl);
        else if (r == 1) step(1'b1, 1'b0, lvl);
        else step(1'b1, 1'b1, lvl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/can_error_frame_rx.md
Name: can_error_frame_rx

Overview:
- Bus-side receiver of CAN error frames. It is the counterpart of the error-flag generator block.
- Watches the sampled bus bit at every sample point and recognises an error flag: 6 or more consecutive dominant bits, including superposed flags from other nodes.
- After the flag it tracks the 8-bit recessive error delimiter and reports flag detection, frame completion, delimiter form errors and excessive dominant bits.
- Sits beside the decoder datapath and feeds the fault-confinement and resync logic.

Parameters:
- FLAG_LEN, 6, consecutive dominant bits that qualify as an error flag.
- MAX_DOM, 12, longest legal dominant run (own flag plus superposed flags); a longer run is flagged as excess.
- DELIM_LEN, 8, recessive bits in the error delimiter.
- CNT_W, 4, width of the dominant and delimiter counters; must hold MAX_DOM+1.

Ports:
- SP  input  1  sample-point clock; one rising edge per bit time.
- reset  input  1  synchronous, active-low reset.
- rx_en  input  1  monitoring enable; 0 forces synchronous clear to IDLE.
- rx_bit  input  1  sampled bus bit; 0 = dominant, 1 = recessive.
- err_flag_det  output  1  one-cycle pulse on the FLAG_LEN-th consecutive dominant bit.
- err_frame_done  output  1  one-cycle pulse on the DELIM_LEN-th delimiter recessive bit.
- delim_err  output  1  one-cycle pulse when a dominant bit appears inside the delimiter.
- excess_dom  output  1  one-cycle pulse when the dominant run reaches MAX_DOM+1.
- in_error  output  1  level; 1 while state is FLAG or DELIM.
- dom_cnt  output  CNT_W  current consecutive-dominant count, saturating at 2^CNT_W-1.

Behaviour:
- General:
  - All logic is clocked on the rising edge of SP.
  - All outputs are registered and change only on SP edges.
  - A pulse is visible for exactly one SP period after the edge that sampled the triggering bit.
- Reset:
  - reset=0 at an edge forces state=IDLE, both counters=0 and every output=0.
  - Reset takes priority over rx_en and over every transition, including mid-flag and mid-delimiter.
- rx_en=0:
  - Same clearing as reset, evaluated after reset.
  - While rx_en=0 the block ignores rx_bit.
- State IDLE:
  - rx_bit=0: dom_cnt increments. When the new value equals FLAG_LEN, go to FLAG and pulse err_flag_det.
  - rx_bit=1: dom_cnt=0; stay in IDLE.
- State FLAG:
  - rx_bit=0: dom_cnt increments, saturating at all-ones. On the edge where the new value equals MAX_DOM+1, pulse excess_dom once; no further excess pulses for the same run. Stay in FLAG.
  - rx_bit=1: go to DELIM, del_cnt=1, dom_cnt=0.
- State DELIM:
  - rx_bit=1: del_cnt increments. When the new value equals DELIM_LEN, pulse err_frame_done, go to IDLE and set del_cnt=0.
  - rx_bit=0: pulse delim_err, go to IDLE with dom_cnt=1 and del_cnt=0. This dominant bit counts as the first bit of a possible new flag, so a further FLAG_LEN-1 dominant bits re-trigger err_flag_det.
- Pulse exclusivity:
  - err_flag_det, err_frame_done and delim_err are mutually exclusive on any edge.
  - excess_dom only ever fires in FLAG, so it never coincides with the others.
- Width rules:
  - Counters are unsigned CNT_W bits.
  - Comparisons use the post-increment value.
  - No wrap-around is permitted; counters saturate.
- in_error:
  - Registered alongside the state, i.e. it equals (next state != IDLE).
  - It rises on the same edge as err_flag_det.
  - It falls on the same edge as err_frame_done or delim_err.

Test Plan:
1. Reset and enable clear:
   - Stimulus: reset=0 for 2 edges with rx_bit=0, then reset=1 and rx_en=1 with rx_bit=1 for 3 edges.
   - Required: all outputs 0 and dom_cnt=0 throughout.
2. Dominant run below flag length:
   - Stimulus: 5 dominant bits, then 1 recessive.
   - Required: dom_cnt reads 1..5 then 0; err_flag_det never asserts; in_error=0.
3. Clean error frame:
   - Stimulus: 6 dominant bits, then 8 recessive.
   - Required: err_flag_det pulses on the 6th edge and in_error rises there; err_frame_done pulses on the 8th recessive edge and in_error falls there.
4. Superposed flag and excess dominant:
   - Stimulus: 15 dominant bits.
   - Required: err_flag_det on the 6th edge; excess_dom only on the 13th edge; dom_cnt saturates at 15 and does not wrap.
5. Delimiter violation and re-detection:
   - Stimulus: 6 dominant, 3 recessive, 1 dominant, then 5 dominant.
   - Required: delim_err pulses on the 10th edge with in_error=0 and dom_cnt=1; err_flag_det pulses again on the 15th edge.
6. Reset and disable mid-operation:
   - Stimulus: 6 dominant, 4 recessive, then reset=0 for one edge, then 4 recessive. Repeat the sequence with rx_en=0 in place of reset.
   - Required: all outputs clear on the reset (or rx_en=0) edge; no err_frame_done follows; state stays IDLE.
